// File: rtl/load_unit_pkg.sv
// Shared opcodes, FSM state encoding and alignment helpers for the load unit.
package load_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
    case (op)
      OP_LW:         return lo != 2'b00;
      OP_LH, OP_LHU: return lo[0];
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Data-bus read port between the load unit (master) and the bus/bridge (slave).
// Handshake: bus_req stays high with bus_addr stable until a cycle where bus_gnt is
// high; bus_rvalid (with bus_rdata) may arrive in that same cycle or any later one.
interface load_unit_if;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_addr,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_addr,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/load_unit_data_ext.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_unit_data_ext
  import load_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [5:0]  opcode,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    data = word;
    case (opcode)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'h0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'h0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// M-stage load unit: issues one word-aligned bus read per load and returns the
// extended result, or flags AdEL (misaligned) / bus timeout.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic        req_ready,
  output logic        busy,
  load_unit_if.master bus,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        exc_adel,
  output logic        exc_bus,
  output state_e      dbg_state
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYC);

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] baddr_q, baddr_d;
  logic        bus_req_q, bus_req_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        adel_q, adel_d;
  logic        ebus_q, ebus_d;
  logic [7:0]  tmo_q, tmo_d;

  logic [31:0] ext_data;
  logic [7:0]  tmo_inc;
  logic        tmo_hit;
  logic        accept;

  load_unit_data_ext u_ext (
    .addr_lo (lo_q),
    .opcode  (op_q),
    .word    (bus.bus_rdata),
    .data    (ext_data)
  );

  assign accept  = (state_q == ST_IDLE) && req_valid && is_load(opcode) && !flush;
  assign tmo_inc = tmo_q + 8'd1;
  assign tmo_hit = (tmo_inc == TMO_LIMIT);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    lo_d      = lo_q;
    baddr_d   = baddr_q;
    bus_req_d = bus_req_q;
    rd_data_d = rd_data_q;
    adel_d    = adel_q;
    ebus_d    = ebus_q;
    tmo_d     = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = opcode;
          lo_d   = addr[1:0];
          tmo_d  = 8'd0;
          adel_d = 1'b0;
          ebus_d = 1'b0;
          if (is_misaligned(opcode, addr[1:0])) begin
            adel_d    = 1'b1;
            rd_data_d = 32'h0;
            state_d   = ST_DONE;
          end else begin
            baddr_d   = {addr[31:2], 2'b00};
            bus_req_d = 1'b1;
            state_d   = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        tmo_d = tmo_inc;
        // Response data beats the timeout; a timeout beats a bare grant.
        if (flush) begin
          bus_req_d = 1'b0;
          state_d   = (bus.bus_gnt && !bus.bus_rvalid && !tmo_hit) ? ST_DRAIN : ST_IDLE;
        end else if (bus.bus_gnt && bus.bus_rvalid) begin
          bus_req_d = 1'b0;
          rd_data_d = ext_data;
          state_d   = ST_DONE;
        end else if (tmo_hit) begin
          bus_req_d = 1'b0;
          ebus_d    = 1'b1;
          rd_data_d = 32'h0;
          state_d   = ST_DONE;
        end else if (bus.bus_gnt) begin
          bus_req_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        tmo_d = tmo_inc;
        if (flush) begin
          state_d = (!bus.bus_rvalid && !tmo_hit) ? ST_DRAIN : ST_IDLE;
        end else if (bus.bus_rvalid) begin
          rd_data_d = ext_data;
          state_d   = ST_DONE;
        end else if (tmo_hit) begin
          ebus_d    = 1'b1;
          rd_data_d = 32'h0;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      ST_DRAIN: begin
        tmo_d = tmo_inc;
        if (bus.bus_rvalid || tmo_hit) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= 6'h0;
      lo_q      <= 2'b00;
      baddr_q   <= 32'h0;
      bus_req_q <= 1'b0;
      rd_data_q <= 32'h0;
      adel_q    <= 1'b0;
      ebus_q    <= 1'b0;
      tmo_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      lo_q      <= lo_d;
      baddr_q   <= baddr_d;
      bus_req_q <= bus_req_d;
      rd_data_q <= rd_data_d;
      adel_q    <= adel_d;
      ebus_q    <= ebus_d;
      tmo_q     <= tmo_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE) && !flush;
  assign busy         = (state_q != ST_IDLE);
  assign rd_valid     = (state_q == ST_DONE) && !flush;
  assign rd_data      = rd_data_q;
  assign exc_adel     = adel_q;
  assign exc_bus      = ebus_q;
  assign bus.bus_req  = bus_req_q;
  assign bus.bus_addr = baddr_q;
  assign dbg_state    = state_q;

endmodule
